alu_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_seq_mul_div_iter.sv | 72 +++++++
 rtl/alu_seq.sv | 158 +++++++++++++++
 tb/tb_alu_seq.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode/state encodings for the sequential ALU.
// Opcodes 8/9 are only legal when the design is built with ALU_DIV_EN.
package alu_pkg;
    localparam int W          = 8;
    localparam int ITER_CNT_W = $clog2(W) + 1;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SHL  = 4'd5,
        OP_SHR  = 4'd6,
        OP_MUL  = 4'd7,
        OP_DIV  = 4'd8,
        OP_MOD  = 4'd9,
        OP_PASS = 4'd10
    } op_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/alu_seq_mul_div_iter.sv
// One-bit-per-cycle shift-add multiplier; restoring divider added under ALU_DIV_EN.
// Outputs show the value after the current step so the caller can capture the last iteration.
module mul_div_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = W
) (
    input  logic             clk,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi
);
    logic [WIDTH-1:0] r_hi, r_lo, r_m;
    logic [WIDTH-1:0] w_hi_nxt, w_lo_nxt, w_lo_ld, w_m_ld;
    logic [WIDTH:0]   w_sum;

    // {hi,lo} is the running product; lo starts as the multiplier and shifts out LSB-first
    assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);

`ifdef ALU_DIV_EN
    logic             r_div;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_rem;
    logic             w_borrow, w_unused_msb;

    assign w_trial = {r_hi, r_lo[WIDTH-1]};
    assign {w_borrow, w_unused_msb, w_rem} = {1'b0, w_trial} - {2'b00, r_m};
    assign w_lo_ld = i_is_div ? i_a : i_b;
    assign w_m_ld  = i_is_div ? i_b : i_a;

    // Restoring division: hi is the partial remainder, lo collects quotient bits
    always_comb begin
        if (r_div) begin
            w_hi_nxt = w_borrow ? w_trial[WIDTH-1:0] : w_rem;
            w_lo_nxt = {r_lo[WIDTH-2:0], ~w_borrow};
        end else begin
            w_hi_nxt = w_sum[WIDTH:1];
            w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (i_load) r_div <= i_is_div;
    end
`else
    logic w_unused_is_div;

    assign w_unused_is_div = i_is_div;
    assign w_lo_ld  = i_b;
    assign w_m_ld   = i_a;
    assign w_hi_nxt = w_sum[WIDTH:1];
    assign w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
`endif

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_hi <= '0;
            r_lo <= w_lo_ld;
            r_m  <= w_m_ld;
        end else if (i_step) begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
        end
    end

    assign o_lo = i_step ? w_lo_nxt : r_lo;
    assign o_hi = i_step ? w_hi_nxt : r_hi;
endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU behind the accumulator register file; single-cycle ops done next cycle,
// MUL (and DIV/MOD when ALU_DIV_EN is defined) iterate reg_width cycles.
module alu_seq
    import alu_pkg::*;
#(
    parameter int reg_width = W,
    parameter int op_width  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [op_width-1:0]  op,
    input  logic [reg_width-1:0] acc_in,
    input  logic [reg_width-1:0] reg_in,
    output logic                 busy,
    output logic                 done,
    output logic                 acc_write,
    output logic [reg_width-1:0] result,
    output logic                 carry,
    output logic                 zero,
    output logic                 illegal
);
    localparam int CNT_W = $clog2(reg_width) + 1;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy, r_done, r_illegal, r_carry, r_zero;
    logic [reg_width-1:0] r_result;

    logic [reg_width-1:0] w_s_res, w_it_res, w_lo, w_hi;
    logic                 w_s_carry, w_s_ill, w_iter, w_it_carry, w_is_div;
    logic [reg_width:0]   w_add, w_sub, w_shl, w_shr;

    assign w_add = {1'b0, acc_in} + {1'b0, reg_in};
    assign w_sub = {1'b0, acc_in} - {1'b0, reg_in};
    // The spare bit of each shift catches the last bit shifted out
    assign w_shl = {1'b0, acc_in} << reg_in[2:0];
    assign w_shr = {acc_in, 1'b0} >> reg_in[2:0];

    always_comb begin
        w_s_res   = '0;
        w_s_carry = 1'b0;
        w_s_ill   = 1'b0;
        w_iter    = 1'b0;
        case (op)
            OP_ADD:  {w_s_carry, w_s_res} = w_add;
            OP_SUB:  {w_s_carry, w_s_res} = w_sub;
            OP_AND:  w_s_res = acc_in & reg_in;
            OP_OR:   w_s_res = acc_in | reg_in;
            OP_XOR:  w_s_res = acc_in ^ reg_in;
            OP_SHL:  {w_s_carry, w_s_res} = w_shl;
            OP_SHR:  {w_s_res, w_s_carry} = w_shr;
            OP_MUL:  w_iter = 1'b1;
`ifdef ALU_DIV_EN
            OP_DIV,
            OP_MOD:  w_iter = 1'b1;
`endif
            OP_PASS: w_s_res = reg_in;
            default: w_s_ill = 1'b1;
        endcase
    end

`ifdef ALU_DIV_EN
    logic [op_width-1:0] r_op;
    logic                r_b_zero;

    assign w_is_div = (op == OP_DIV) || (op == OP_MOD);

    always_comb begin
        if (r_op == OP_MUL) begin
            w_it_res   = w_lo;
            w_it_carry = |w_hi;
        end else begin
            w_it_res   = (r_op == OP_MOD) ? w_hi : w_lo;
            w_it_carry = r_b_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= '0;
            r_b_zero <= 1'b0;
        end else if (start && r_state != RUN) begin
            r_op     <= op;
            r_b_zero <= (reg_in == '0);
        end
    end
`else
    assign w_is_div   = 1'b0;
    assign w_it_res   = w_lo;
    assign w_it_carry = |w_hi;
`endif

    mul_div_iter #(.WIDTH(reg_width)) u_iter (
        .clk      (clk),
        .i_load   (start && w_iter && r_state != RUN),
        .i_step   (r_state == RUN),
        .i_is_div (w_is_div),
        .i_a      (acc_in),
        .i_b      (reg_in),
        .o_lo     (w_lo),
        .o_hi     (w_hi)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b0;
            r_result  <= '0;
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start && w_iter) begin
                        r_state <= RUN;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end else if (start) begin
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        r_result  <= w_s_res;
                        r_carry   <= w_s_carry;
                        r_zero    <= (w_s_res == '0);
                        r_illegal <= w_s_ill;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(reg_width - 1)) begin
                        r_state  <= DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_result <= w_it_res;
                        r_carry  <= w_it_carry;
                        r_zero   <= (w_it_res == '0);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign acc_write = r_done;
    assign result    = r_result;
    assign carry     = r_carry;
    assign zero      = r_zero;
    assign illegal   = r_illegal;
endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq against an arithmetic reference model.
// Honours ALU_DIV_EN the same way the design does.
module tb_alu_seq;
`ifdef ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, start;
    logic [3:0] op;
    logic [7:0] acc_in, reg_in;
    logic       busy, done, acc_write, carry, zero, illegal;
    logic [7:0] result;
    int         n_chk  = 0;
    int         n_pass = 0;

    alu_seq #(.reg_width(8), .op_width(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .acc_in    (acc_in),
        .reg_in    (reg_in),
        .busy      (busy),
        .done      (done),
        .acc_write (acc_write),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic bit is_iter(input int o);
        return (o == 7) || (DIV_EN && (o == 8 || o == 9));
    endfunction

    function automatic void model(input int o, input int a, input int b,
                                  output int res, output int c, output int ill);
        int amt, p;
        amt = b % 8;
        res = 0; c = 0; ill = 0;
        case (o)
            0: begin res = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
            1: begin res = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: begin res = (a * (1 << amt)) % 256; c = (amt != 0) ? ((a >> (8 - amt)) % 2) : 0; end
            6: begin res = a / (1 << amt); c = (amt != 0) ? ((a >> (amt - 1)) % 2) : 0; end
            7: begin p = a * b; res = p % 256; c = (p > 255) ? 1 : 0; end
            8: if (!DIV_EN) ill = 1;
               else if (b == 0) begin res = 255; c = 1; end
               else res = a / b;
            9: if (!DIV_EN) ill = 1;
               else if (b == 0) begin res = a; c = 1; end
               else res = a % b;
            10: res = b;
            default: ill = 1;
        endcase
    endfunction

    // Issue one op, then walk the exact expected latency checking busy/done and the final outputs
    task automatic do_op(input int o, input int a, input int b);
        int res, c, ill, lat;
        model(o, a, b, res, c, ill);
        lat = is_iter(o) ? 9 : 1;
        @(negedge clk);
        start = 1'b1; op = o[3:0]; acc_in = a[7:0]; reg_in = b[7:0];
        @(negedge clk);
        start = 1'b0; op = 4'($urandom); acc_in = 8'($urandom); reg_in = 8'($urandom);
        for (int k = 1; k < lat; k++) begin
            chk("run_busy", 32'(busy), 32'(1));
            chk("run_done", 32'(done), 32'(0));
            @(negedge clk);
        end
        chk($sformatf("done op%0d", o), 32'(done), 32'(1));
        chk("acc_write", 32'(acc_write), 32'(1));
        chk($sformatf("result op%0d %0h,%0h", o, a, b), 32'(result), 32'(res));
        chk($sformatf("carry op%0d %0h,%0h", o, a, b), 32'(carry), 32'(c));
        chk("zero", 32'(zero), (res == 0) ? 32'(1) : 32'(0));
        chk("illegal", 32'(illegal), 32'(ill));
        chk("busy_at_done", 32'(busy), 32'(0));
    endtask

    initial begin
        int a, b, o;
        bit saw_done;
        reset = 1'b1; start = 1'b0; op = '0; acc_in = '0; reg_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_result", 32'(result), 32'(0));
        chk("rst_flags", {29'd0, carry, zero, illegal}, 32'(0));
        reset = 1'b0;

        do_op(0, 'hF0, 'h20);
        @(negedge clk);
        chk("add_done_low", 32'(done), 32'(0));
        chk("add_result_held", 32'(result), 32'(8'h10));
        do_op(1, 'h05, 'h05);
        do_op(1, 'h03, 'h05);
        do_op(5, 'h81, 1);
        do_op(6, 'h81, 0);
        do_op(15, 'h12, 'h34);

        // MUL with a start during RUN (must be ignored) and a back-to-back start at done
        @(negedge clk);
        start = 1'b1; op = 4'd7; acc_in = 8'h10; reg_in = 8'h11;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("mul_busy", 32'(busy), 32'(1));
            chk("mul_done", 32'(done), 32'(0));
            start = (k == 2); op = 4'd0; acc_in = 8'h01; reg_in = 8'h01;
        end
        @(negedge clk);
        chk("mul_done9", 32'(done), 32'(1));
        chk("mul_result", 32'(result), 32'(8'h10));
        chk("mul_carry", 32'(carry), 32'(1));
        start = 1'b1; op = 4'd0; acc_in = 8'h01; reg_in = 8'h02;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_done", 32'(done), 32'(1));
        chk("b2b_result", 32'(result), 32'(8'h03));
        chk("b2b_carry", 32'(carry), 32'(0));

        // Reset in the middle of a MUL
        do_op(0, 'hF0, 'h20);
        @(negedge clk);
        start = 1'b1; op = 4'd7; acc_in = 8'hFF; reg_in = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'(1));
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_result", 32'(result), 32'(0));
        chk("midrst_flags", {29'd0, carry, zero, illegal}, 32'(0));
        reset = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        chk("midrst_no_done", 32'(saw_done), 32'(0));

        do_op(8, 200, 7);
        do_op(9, 200, 7);
        do_op(8, 'h33, 0);
        do_op(9, 'h33, 0);

        for (int n = 0; n < 60; n++) begin
            o = int'($urandom_range(0, 15));
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            do_op(o, a, b);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
